lsu_mem_responder: RTL and testbench

- Memory-side responder for the load/store unit's data accesses.
- Accepts one load or store request at a time over a valid/ready handshake and applies a programmable wait-state delay.
- Performs RV32 byte, half and word access sizing on a word-organised local RAM, then returns one response over a second valid/ready handshake.
- Sits between the CPU data port and the data RAM; it is the target end of the interface that the load/store unit drives.

---
 rtl/lsu_mem_responder.sv | 166 ++++++++++++++++
 tb/tb_lsu_mem_responder.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/lsu_mem_responder.sv
// Memory-side responder for LSU data accesses: wait-state delay, RV32 byte/half/word sizing on a word RAM.
// Optional LSU_MEM_ALIGN_FAULT_EN: misaligned half/word accesses become errors instead of being aligned down.
module lsu_mem_responder #(
  parameter int          DEPTH_WORDS = 256,
  parameter int          WAIT_STATES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_2000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int          IDX_W   = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN    = 32'(DEPTH_WORDS * 4);
  localparam logic [3:0]  WS_LOAD = 4'(WAIT_STATES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;

  logic        write_p0;
  logic [31:0] addr_p0;
  logic [31:0] wdata_p0;
  logic [2:0]  funct3_p0;

  logic [31:0] mem [DEPTH_WORDS];

  logic [31:0]      offset;
  logic [IDX_W-1:0] idx;
  logic [1:0]       lane;
  logic             in_range;
  logic             f3_ok;
  logic             misalign;
  logic             err;
  logic             commit;
  logic [31:0]      word_rd;
  logic [31:0]      load_data;
  logic [3:0]       be;
  logic [31:0]      wlane;

  function automatic logic [31:0] ext8(input logic [7:0] b, input logic sx);
    logic signed [7:0]  s;
    logic signed [31:0] r;
    s = b;
    r = s;
    return sx ? r : {24'b0, b};
  endfunction

  function automatic logic [31:0] ext16(input logic [15:0] h, input logic sx);
    logic signed [15:0] s;
    logic signed [31:0] r;
    s = h;
    r = s;
    return sx ? r : {16'b0, h};
  endfunction

  assign req_ready = (state == S_IDLE);
  assign rsp_valid = (state == S_RESP);

  // Request capture stage: operands frozen while the access waits and commits
  always_ff @(posedge clk) begin
    if (state == S_IDLE && req_valid) begin
      write_p0  <= req_write;
      addr_p0   <= req_addr;
      wdata_p0  <= req_wdata;
      funct3_p0 <= req_funct3;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE: if (req_valid) begin
        state_nxt = S_WAIT;
        cnt_nxt   = WS_LOAD;
      end
      S_WAIT: begin
        if (cnt == 4'd0) state_nxt = S_RESP;
        else             cnt_nxt   = cnt - 4'd1;
      end
      S_RESP: if (rsp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Commit stage: unsigned offset makes addresses below BASE_ADDR wrap to huge values, so they fail the range test
  always_comb begin
    offset   = addr_p0 - BASE_ADDR;
    in_range = (offset < SPAN);
    idx      = offset[IDX_W+1:2];
    lane     = addr_p0[1:0];
    commit   = (state == S_WAIT) && (cnt == 4'd0);
    if (write_p0) f3_ok = (funct3_p0 == 3'b000) || (funct3_p0 == 3'b001) || (funct3_p0 == 3'b010);
    else          f3_ok = (funct3_p0 != 3'b011) && (funct3_p0 != 3'b110) && (funct3_p0 != 3'b111);
`ifdef LSU_MEM_ALIGN_FAULT_EN
    misalign = ((funct3_p0[1:0] == 2'b01) && lane[0]) ||
               ((funct3_p0[1:0] == 2'b10) && (lane != 2'b00));
`else
    misalign = 1'b0;
`endif
    err     = !in_range || !f3_ok || misalign;
    word_rd = mem[idx];

    case (funct3_p0[1:0])
      2'b00:   load_data = ext8(word_rd[8*lane +: 8], !funct3_p0[2]);
      2'b01:   load_data = ext16(lane[1] ? word_rd[31:16] : word_rd[15:0], !funct3_p0[2]);
      default: load_data = word_rd;
    endcase

    case (funct3_p0[1:0])
      2'b00: begin
        be    = 4'b0001 << lane;
        wlane = {4{wdata_p0[7:0]}};
      end
      2'b01: begin
        be    = lane[1] ? 4'b1100 : 4'b0011;
        wlane = {2{wdata_p0[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wlane = wdata_p0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (commit && write_p0 && !err) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wlane[8*i +: 8];
      end
    end
  end

  // Response stage: result held until the requester takes it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else if (commit) begin
      rsp_rdata <= (err || write_p0) ? 32'd0 : load_data;
      rsp_err   <= err;
    end
  end

endmodule

// File: tb/tb_lsu_mem_responder.sv
// Directed self-checking bench for lsu_mem_responder (WAIT_STATES=2, 256 words at 0x2000).
module tb_lsu_mem_responder;

  localparam int WS = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int n_tests = 0;
  int n_fail  = 0;

  lsu_mem_responder #(
    .DEPTH_WORDS(256),
    .WAIT_STATES(WS),
    .BASE_ADDR  (32'h0000_2000)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_funct3(req_funct3),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One request/response; hold = cycles rsp_ready stays low once the response is up
  task automatic txn(input string tag, input logic w, input logic [31:0] a, input logic [31:0] wd,
                     input logic [2:0] f3, input logic [31:0] exp_rd, input logic exp_err, input int hold);
    int lat;
    req_valid  = 1'b1;
    req_write  = w;
    req_addr   = a;
    req_wdata  = wd;
    req_funct3 = f3;
    @(posedge clk); #1;
    req_valid  = 1'b0;
    req_addr   = 32'hFFFF_FFFF;
    req_wdata  = 32'h5A5A_5A5A;
    req_funct3 = 3'b111;
    lat = 0;
    while (!rsp_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, ".lat"}, 32'(lat), 32'(WS + 1));
    chk({tag, ".rdata"}, rsp_rdata, exp_rd);
    chk({tag, ".err"}, {31'd0, rsp_err}, {31'd0, exp_err});
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, ".hold_valid"}, {31'd0, rsp_valid}, 32'd1);
      chk({tag, ".hold_rdata"}, rsp_rdata, exp_rd);
      chk({tag, ".hold_ready"}, {31'd0, req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk({tag, ".post_ready"}, {31'd0, req_ready}, 32'd1);
    chk({tag, ".post_valid"}, {31'd0, rsp_valid}, 32'd0);
  endtask

  initial begin
    reset      = 1'b0;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    req_funct3 = 3'd0;
    rsp_ready  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst.rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst.rsp_rdata", rsp_rdata, 32'd0);
    chk("rst.rsp_err",   {31'd0, rsp_err}, 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    txn("sw2004", 1'b1, 32'h2004, 32'hDEAD_BEEF, 3'b010, 32'd0, 1'b0, 0);
    txn("lw2004", 1'b0, 32'h2004, 32'd0, 3'b010, 32'hDEAD_BEEF, 1'b0, 0);

    txn("sw2008", 1'b1, 32'h2008, 32'd0, 3'b010, 32'd0, 1'b0, 0);
    txn("sb200b", 1'b1, 32'h200B, 32'h1234_5680, 3'b000, 32'd0, 1'b0, 0);
    txn("lw2008a", 1'b0, 32'h2008, 32'd0, 3'b010, 32'h8000_0000, 1'b0, 0);
    txn("lb200b", 1'b0, 32'h200B, 32'd0, 3'b000, 32'hFFFF_FF80, 1'b0, 0);
    txn("lbu200b", 1'b0, 32'h200B, 32'd0, 3'b100, 32'h0000_0080, 1'b0, 0);
    txn("sh2008", 1'b1, 32'h2008, 32'hABCD_1234, 3'b001, 32'd0, 1'b0, 0);
    txn("lhu2008", 1'b0, 32'h2008, 32'd0, 3'b101, 32'h0000_1234, 1'b0, 0);
    txn("lw2008b", 1'b0, 32'h2008, 32'd0, 3'b010, 32'h8000_1234, 1'b0, 0);
    txn("lh200a", 1'b0, 32'h200A, 32'd0, 3'b001, 32'hFFFF_8000, 1'b0, 0);

    txn("bp_lw", 1'b0, 32'h2004, 32'd0, 3'b010, 32'hDEAD_BEEF, 1'b0, 5);

    txn("lw1ffc", 1'b0, 32'h1FFC, 32'd0, 3'b010, 32'd0, 1'b1, 0);
    txn("sw23fc", 1'b1, 32'h23FC, 32'h0BAD_F00D, 3'b010, 32'd0, 1'b0, 0);
    txn("sw2400", 1'b1, 32'h2400, 32'hFFFF_FFFF, 3'b010, 32'd0, 1'b1, 0);
    txn("lw23fc", 1'b0, 32'h23FC, 32'd0, 3'b010, 32'h0BAD_F00D, 1'b0, 0);
    txn("ld_f3_011", 1'b0, 32'h2004, 32'd0, 3'b011, 32'd0, 1'b1, 0);
    txn("st_f3_100", 1'b1, 32'h2004, 32'h0, 3'b100, 32'd0, 1'b1, 0);
    txn("lw2004c", 1'b0, 32'h2004, 32'd0, 3'b010, 32'hDEAD_BEEF, 1'b0, 0);

    txn("sw_cafe", 1'b1, 32'h2004, 32'hCAFE_F00D, 3'b010, 32'd0, 1'b0, 0);
`ifdef LSU_MEM_ALIGN_FAULT_EN
    txn("lw2006", 1'b0, 32'h2006, 32'd0, 3'b010, 32'd0, 1'b1, 0);
`else
    txn("lw2006", 1'b0, 32'h2006, 32'd0, 3'b010, 32'hCAFE_F00D, 1'b0, 0);
`endif

    txn("sw2010", 1'b1, 32'h2010, 32'h55AA_55AA, 3'b010, 32'd0, 1'b0, 0);
    req_valid  = 1'b1;
    req_write  = 1'b1;
    req_addr   = 32'h2010;
    req_wdata  = 32'h1111_1111;
    req_funct3 = 3'b010;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("rstw.in_wait", {31'd0, req_ready}, 32'd0);
    reset = 1'b0;
    #1;
    chk("rstw.async_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("rstw.rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rstw.req_ready", {31'd0, req_ready}, 32'd1);
    txn("lw2010", 1'b0, 32'h2010, 32'd0, 3'b010, 32'h55AA_55AA, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
